// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory access arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 15;

    // Timer must hold 0..TIMEOUT-1; keep at least one bit when timeout is disabled.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Two-way request picker: fixed A priority or round-robin on the last grant.
module dmem_rr_picker
    import dmem_arb_pkg::*;
#(
    parameter bit PRIO_A = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req_a,
    input  logic       req_b,
    output logic [1:0] gnt_c
);

    logic last_gnt;

    // On a tie, A wins under fixed priority or when B was served last.
    always_comb begin
        gnt_c = '0;
        if (en) begin
            if (req_a && (!req_b || PRIO_A || (last_gnt == REQ_B))) begin
                gnt_c = 2'b01;
            end else if (req_b) begin
                gnt_c = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= REQ_B;
        end else if (gnt_c[0]) begin
            last_gnt <= REQ_A;
        end else if (gnt_c[1]) begin
            last_gnt <= REQ_B;
        end
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares one data-memory port between the core load/store path (A) and an auxiliary master (B),
// one transaction at a time with optional timeout abort.
module dmem_access_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter bit          PRIO_A  = 1'b0
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                a_req_in,
    input  logic                a_we_in,
    input  logic [ADDR_W-1:0]   a_addr_in,
    input  logic [DATA_W-1:0]   a_wdata_in,
    input  logic [DATA_W/8-1:0] a_mask_in,
    input  logic                b_req_in,
    input  logic                b_we_in,
    input  logic [ADDR_W-1:0]   b_addr_in,
    input  logic [DATA_W-1:0]   b_wdata_in,
    input  logic [DATA_W/8-1:0] b_mask_in,
    output logic                a_gnt_out,
    output logic                b_gnt_out,
    output logic                a_done_out,
    output logic                b_done_out,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                err_out,
    output logic                mem_req_out,
    output logic                mem_we_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic [DATA_W-1:0]   mem_wdata_out,
    output logic [DATA_W/8-1:0] mem_mask_out,
    input  logic                mem_ack_in,
    input  logic [DATA_W-1:0]   mem_rdata_in
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned TMR_W  = timer_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         gnt_c;

    logic               a_done_d, b_done_d, err_d, mem_req_d, mem_we_d;
    logic [DATA_W-1:0]  rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [MASK_W-1:0]  mem_mask_d;

    // Grants only in IDLE and never while reset is held.
    dmem_rr_picker #(
        .PRIO_A (PRIO_A)
    ) u_picker (
        .clk    (clk_in),
        .rst_n  (rst_n_in),
        .en     ((state_q == ST_IDLE) && rst_n_in),
        .req_a  (a_req_in),
        .req_b  (b_req_in),
        .gnt_c  (gnt_c)
    );

    assign a_gnt_out = gnt_c[0];
    assign b_gnt_out = gnt_c[1];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        timer_d     = timer_q;
        a_done_d    = 1'b0;
        b_done_d    = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_out;
        mem_req_d   = mem_req_out;
        mem_we_d    = mem_we_out;
        mem_addr_d  = mem_addr_out;
        mem_wdata_d = mem_wdata_out;
        mem_mask_d  = mem_mask_out;

        case (state_q)
            ST_IDLE: begin
                if (|gnt_c) begin
                    state_d   = ST_WAIT;
                    timer_d   = '0;
                    mem_req_d = 1'b1;
                    if (gnt_c[1]) begin
                        owner_d     = REQ_B;
                        mem_we_d    = b_we_in;
                        mem_addr_d  = b_addr_in;
                        mem_wdata_d = b_wdata_in;
                        mem_mask_d  = b_we_in ? b_mask_in : '0;
                    end else begin
                        owner_d     = REQ_A;
                        mem_we_d    = a_we_in;
                        mem_addr_d  = a_addr_in;
                        mem_wdata_d = a_wdata_in;
                        mem_mask_d  = a_we_in ? a_mask_in : '0;
                    end
                end
            end
            ST_WAIT: begin
                // Ack takes precedence over a coincident timeout.
                if (mem_ack_in || ((TIMEOUT != 0) && (timer_q == TMR_LAST))) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    a_done_d  = (owner_q == REQ_A);
                    b_done_d  = (owner_q == REQ_B);
                    err_d     = !mem_ack_in;
                    if (mem_ack_in && !mem_we_out) begin
                        rdata_d = mem_rdata_in;
                    end
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            owner_q       <= REQ_A;
            timer_q       <= '0;
            a_done_out    <= 1'b0;
            b_done_out    <= 1'b0;
            err_out       <= 1'b0;
            rdata_out     <= '0;
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            mem_mask_out  <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            timer_q       <= timer_d;
            a_done_out    <= a_done_d;
            b_done_out    <= b_done_d;
            err_out       <= err_d;
            rdata_out     <= rdata_d;
            mem_req_out   <= mem_req_d;
            mem_we_out    <= mem_we_d;
            mem_addr_out  <= mem_addr_d;
            mem_wdata_out <= mem_wdata_d;
            mem_mask_out  <= mem_mask_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter; a second instance runs with fixed A priority.
module tb_dmem_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_req, a_we, b_req, b_we, mem_ack;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata, mem_rdata;
    logic [3:0]  a_mask, b_mask;

    logic        a_gnt, b_gnt, a_done, b_done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;

    logic        p_a_gnt, p_b_gnt, p_a_done, p_b_done, p_err, p_mem_req, p_mem_we;
    logic [31:0] p_rdata, p_mem_addr, p_mem_wdata;
    logic [3:0]  p_mem_mask;

    int checks = 0;
    int errors = 0;

    wire [5:0] st   = {a_gnt, b_gnt, a_done, b_done, err, mem_req};
    wire [5:0] p_st = {p_a_gnt, p_b_gnt, p_a_done, p_b_done, p_err, p_mem_req};

    dmem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .PRIO_A(1'b0)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .a_req_in(a_req), .a_we_in(a_we), .a_addr_in(a_addr), .a_wdata_in(a_wdata), .a_mask_in(a_mask),
        .b_req_in(b_req), .b_we_in(b_we), .b_addr_in(b_addr), .b_wdata_in(b_wdata), .b_mask_in(b_mask),
        .a_gnt_out(a_gnt), .b_gnt_out(b_gnt), .a_done_out(a_done), .b_done_out(b_done),
        .rdata_out(rdata), .err_out(err),
        .mem_req_out(mem_req), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
        .mem_wdata_out(mem_wdata), .mem_mask_out(mem_mask),
        .mem_ack_in(mem_ack), .mem_rdata_in(mem_rdata)
    );

    dmem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .PRIO_A(1'b1)) dut_prio (
        .clk_in(clk), .rst_n_in(rst_n),
        .a_req_in(a_req), .a_we_in(a_we), .a_addr_in(a_addr), .a_wdata_in(a_wdata), .a_mask_in(a_mask),
        .b_req_in(b_req), .b_we_in(b_we), .b_addr_in(b_addr), .b_wdata_in(b_wdata), .b_mask_in(b_mask),
        .a_gnt_out(p_a_gnt), .b_gnt_out(p_b_gnt), .a_done_out(p_a_done), .b_done_out(p_b_done),
        .rdata_out(p_rdata), .err_out(p_err),
        .mem_req_out(p_mem_req), .mem_we_out(p_mem_we), .mem_addr_out(p_mem_addr),
        .mem_wdata_out(p_mem_wdata), .mem_mask_out(p_mem_mask),
        .mem_ack_in(mem_ack), .mem_rdata_in(mem_rdata)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_mask = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_mask = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        a_req = 1'b1; b_req = 1'b1; mem_ack = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({st, rdata, mem_we, mem_addr, mem_wdata, mem_mask} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got st=%b rdata=%h we=%b addr=%h wdata=%h mask=%h expected all 0",
                     st, rdata, mem_we, mem_addr, mem_wdata, mem_mask);
        end
        checks++;
        if ({p_st, p_rdata, p_mem_we, p_mem_addr, p_mem_wdata, p_mem_mask} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_prio got st=%b expected all 0", p_st);
        end
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_a_read();
        logic [5:0] exp_st;
        for (int c = 0; c < 7; c++) begin
            a_req = (c == 0); a_we = 1'b0; a_addr = 32'h100; a_mask = 4'hF;
            mem_ack = (c == 4); mem_rdata = (c == 4) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk);
            exp_st = {c == 0, 1'b0, c == 5, 1'b0, 1'b0, (c >= 1) && (c <= 4)};
            checks++;
            if (st !== exp_st) begin
                errors++;
                $display("FAIL a_read_ctl cycle %0d got %b expected %b", c, st, exp_st);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if ({mem_we, mem_addr, mem_mask} !== {1'b0, 32'h100, 4'h0}) begin
                    errors++;
                    $display("FAIL a_read_port cycle %0d got we=%b addr=%h mask=%h expected 0/00000100/0",
                             c, mem_we, mem_addr, mem_mask);
                end
            end
            if (c == 5) begin
                checks++;
                if (rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL a_read_rdata got %h expected deadbeef", rdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_b_write();
        logic [5:0] exp_st;
        for (int c = 0; c < 6; c++) begin
            b_req   = (c == 0);
            b_we    = (c == 0);
            b_addr  = (c == 0) ? 32'h2 : 32'hFFFF_FFFF;
            b_wdata = (c == 0) ? 32'h00AB_0000 : 32'h0;
            b_mask  = (c == 0) ? 4'b0100 : 4'b1011;
            mem_ack = (c == 3); mem_rdata = 32'h1111_2222;
            @(negedge clk);
            exp_st = {1'b0, c == 0, 1'b0, c == 4, 1'b0, (c >= 1) && (c <= 3)};
            checks++;
            if (st !== exp_st) begin
                errors++;
                $display("FAIL b_write_ctl cycle %0d got %b expected %b", c, st, exp_st);
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata, mem_mask} !== {1'b1, 32'h2, 32'h00AB_0000, 4'b0100}) begin
                    errors++;
                    $display("FAIL b_write_port cycle %0d got we=%b addr=%h wdata=%h mask=%b expected 1/00000002/00ab0000/0100",
                             c, mem_we, mem_addr, mem_wdata, mem_mask);
                end
            end
            if (c == 4) begin
                checks++;
                if (rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL b_write_rdata_hold got %h expected deadbeef", rdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_b_read();
        logic [5:0] exp_st;
        for (int c = 0; c < 3; c++) begin
            b_req = (c == 0); b_we = 1'b0; b_addr = 32'h40; b_mask = 4'hF; b_wdata = 32'h1111_1111;
            mem_ack = (c == 1); mem_rdata = 32'h1234_5678;
            @(negedge clk);
            exp_st = {1'b0, c == 0, 1'b0, c == 2, 1'b0, c == 1};
            checks++;
            if (st !== exp_st) begin
                errors++;
                $display("FAIL b_read_ctl cycle %0d got %b expected %b", c, st, exp_st);
            end
            if (c == 1) begin
                checks++;
                if ({mem_we, mem_addr, mem_mask} !== {1'b0, 32'h40, 4'h0}) begin
                    errors++;
                    $display("FAIL b_read_port got we=%b addr=%h mask=%h expected 0/00000040/0",
                             mem_we, mem_addr, mem_mask);
                end
            end
            if (c == 2) begin
                checks++;
                if (rdata !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL b_read_rdata got %h expected 12345678", rdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_timeout(input int ack_cyc);
        logic [5:0] exp_st;
        for (int c = 0; c < 18; c++) begin
            a_req = (c == 0); a_we = 1'b0; a_addr = 32'h300;
            mem_ack = (c == ack_cyc); mem_rdata = (c == ack_cyc) ? 32'hCAFE_F00D : 32'h0;
            @(negedge clk);
            exp_st = {c == 0, 1'b0, c == 16, 1'b0, (c == 16) && (ack_cyc < 0), (c >= 1) && (c <= 15)};
            checks++;
            if (st !== exp_st) begin
                errors++;
                $display("FAIL timeout_ack%0d cycle %0d got %b expected %b", ack_cyc, c, st, exp_st);
            end
            if (c == 16 && ack_cyc >= 0) begin
                checks++;
                if (rdata !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("FAIL timeout_late_ack_rdata got %h expected cafef00d", rdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_arbitration();
        logic [1:0]  exp_g, exp_pg;
        logic [31:0] exp_addr;
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            a_req = (c < 8); a_addr = 32'hA0;
            b_req = (c < 8); b_addr = 32'hB0;
            mem_ack = mem_req; mem_rdata = 32'h0;
            @(negedge clk);
            exp_g  = 2'b00;
            exp_pg = 2'b00;
            if (c < 8 && (c % 2) == 0) begin
                exp_g  = (((c / 2) % 2) == 0) ? 2'b10 : 2'b01;
                exp_pg = 2'b10;
            end
            checks++;
            if ({a_gnt, b_gnt} !== exp_g) begin
                errors++;
                $display("FAIL rr_grant cycle %0d got ab=%b expected %b", c, {a_gnt, b_gnt}, exp_g);
            end
            checks++;
            if ({p_a_gnt, p_b_gnt} !== exp_pg) begin
                errors++;
                $display("FAIL prio_grant cycle %0d got ab=%b expected %b", c, {p_a_gnt, p_b_gnt}, exp_pg);
            end
            if ((c % 2) == 1) begin
                exp_addr = (((c / 2) % 2) == 0) ? 32'hA0 : 32'hB0;
                checks++;
                if (mem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL rr_addr cycle %0d got %h expected %h", c, mem_addr, exp_addr);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        logic [5:0] exp_tbl [9];
        exp_tbl = '{6'b100000, 6'b000001, 6'b000001, 6'b000000, 6'b100000,
                    6'b000001, 6'b011000, 6'b000001, 6'b000100};
        for (int c = 0; c < 9; c++) begin
            rst_n = !(c == 2 || c == 3);
            a_req = (c == 0) || (c >= 2 && c <= 4); a_we = 1'b0; a_addr = 32'h500;
            b_req = (c >= 2 && c <= 6);             b_we = 1'b0; b_addr = 32'h600;
            mem_ack = (c == 5) || (c == 7);
            mem_rdata = (c == 5) ? 32'h7777_7777 : ((c == 7) ? 32'h5A5A_5A5A : 32'h0);
            @(negedge clk);
            checks++;
            if (st !== exp_tbl[c]) begin
                errors++;
                $display("FAIL reset_mid_ctl cycle %0d got %b expected %b", c, st, exp_tbl[c]);
            end
            if (c == 3) begin
                checks++;
                if ({rdata, mem_we, mem_addr, mem_wdata, mem_mask} !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_clear got rdata=%h addr=%h expected all 0", rdata, mem_addr);
                end
            end
            if (c == 5 || c == 7) begin
                checks++;
                if (mem_addr !== ((c == 5) ? 32'h500 : 32'h600)) begin
                    errors++;
                    $display("FAIL reset_mid_addr cycle %0d got %h expected %h", c, mem_addr,
                             (c == 5) ? 32'h500 : 32'h600);
                end
            end
            if (c == 8) begin
                checks++;
                if (rdata !== 32'h5A5A_5A5A) begin
                    errors++;
                    $display("FAIL reset_mid_rdata got %h expected 5a5a5a5a", rdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_spurious_ack();
        for (int c = 0; c < 2; c++) begin
            mem_ack = (c == 0); mem_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            checks++;
            if ({st, rdata} !== {6'b000000, 32'h5A5A_5A5A}) begin
                errors++;
                $display("FAIL spurious_ack cycle %0d got st=%b rdata=%h expected 000000/5a5a5a5a", c, st, rdata);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_a_read();
        test_b_write();
        test_b_read();
        test_timeout(-1);
        test_timeout(15);
        test_arbitration();
        test_reset_mid_wait();
        test_spurious_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
